// File: rtl/game_beam_gen.sv
// game_beam_gen: 640x480@60 VGA raster generator with an integer-scaled
// game window (default 224x288) placed inside the visible area.
// Produces pin-level hsync/vsync/vga_de plus game-space beam signals
// (sx, sy, game_pix_stb, frame_stb, display_enabled).
// All outputs are registered and show the counter state of the previous
// cycle.
// Optional feature: define GAME_BEAM_FRAME_CNT_EN to build a 16-bit
// frame counter on frame_cnt. Without it, frame_cnt is tied to 0.
module game_beam_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int GAME_W   = 224,
  parameter int GAME_H   = 288,
  parameter int SCALE    = 1,
  parameter int H_OFFSET = 208,
  parameter int V_OFFSET = 96
) (
  input  logic        vga_pix_clk,
  input  logic        rst,
  output logic        hsync,
  output logic        vsync,
  output logic        vga_de,
  output logic [7:0]  sx,
  output logic [8:0]  sy,
  output logic        game_pix_stb,
  output logic        frame_stb,
  output logic        display_enabled,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Reject window placements that fall off the visible area, bad scale
  // factors, and rasters too large for the 10-bit beam counters.
  if (H_OFFSET + GAME_W * SCALE > H_ACTIVE) begin : g_chk_h
    $error("game_beam_gen: window exceeds H_ACTIVE");
  end
  if (V_OFFSET + GAME_H * SCALE > V_ACTIVE) begin : g_chk_v
    $error("game_beam_gen: window exceeds V_ACTIVE");
  end
  if (SCALE < 1 || SCALE > 4) begin : g_chk_s
    $error("game_beam_gen: SCALE must be 1..4");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_chk_t
    $error("game_beam_gen: raster too large for 10-bit counters");
  end

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] WX0      = 10'(H_OFFSET);
  localparam logic [9:0] WY0      = 10'(V_OFFSET);
  localparam logic [9:0] WIN_W    = 10'(GAME_W * SCALE);
  localparam logic [9:0] WIN_H    = 10'(GAME_H * SCALE);
  localparam logic [1:0] SUB_LAST = 2'(SCALE - 1);

  // Beam state
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic [1:0] hsub_q, hsub_d;
  logic [1:0] vsub_q, vsub_d;
  logic [7:0] sx_q, sx_d;
  logic [8:0] sy_q, sy_d;

  // Registered outputs
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       de_q, de_d;
  logic [7:0] sx_out_q, sx_out_d;
  logic [8:0] sy_out_q, sy_out_d;
  logic       pix_stb_q, pix_stb_d;
  logic       frame_stb_q, frame_stb_d;
  logic       disp_q, disp_d;

  // Window-relative positions. Left of/above the window the 10-bit
  // difference wraps to a value no smaller than the window size, so a
  // single compare covers both edges.
  logic [9:0] h_rel, v_rel;
  logic       h_in, v_in, in_win, line_end;

  // Next-state logic for the beam, sub-pixel and game-coordinate counters
  // plus the decoded output values.
  always_comb begin
    h_rel    = hcnt_q - WX0;
    v_rel    = vcnt_q - WY0;
    h_in     = h_rel < WIN_W;
    v_in     = v_rel < WIN_H;
    in_win   = h_in && v_in;
    line_end = hcnt_q == H_LAST;

    hcnt_d = line_end ? 10'd0 : hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (line_end) begin
      vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
    end

    // Horizontal sub-pixel / column: advance across the window, and sit at
    // zero everywhere else so the left edge always starts from 0.
    hsub_d = 2'd0;
    sx_d   = 8'd0;
    if (h_in && h_rel != WIN_W - 10'd1) begin
      if (hsub_q == SUB_LAST) begin
        sx_d = sx_q + 8'd1;
      end else begin
        hsub_d = hsub_q + 2'd1;
        sx_d   = sx_q;
      end
    end

    // Vertical sub-pixel / row: only move at line ends; zero outside the
    // window rows so the first window line starts from 0.
    vsub_d = vsub_q;
    sy_d   = sy_q;
    if (line_end) begin
      vsub_d = 2'd0;
      sy_d   = 9'd0;
      if (v_in && v_rel != WIN_H - 10'd1) begin
        if (vsub_q == SUB_LAST) begin
          sy_d = sy_q + 9'd1;
        end else begin
          vsub_d = vsub_q + 2'd1;
          sy_d   = sy_q;
        end
      end
    end

    hsync_d     = !(hcnt_q >= HS_START && hcnt_q < HS_END);
    vsync_d     = !(vcnt_q >= VS_START && vcnt_q < VS_END);
    de_d        = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    sx_out_d    = in_win ? sx_q : 8'd0;
    sy_out_d    = in_win ? sy_q : 9'd0;
    pix_stb_d   = in_win && (hsub_q == 2'd0);
    frame_stb_d = in_win && (sx_q == 8'd0) && (sy_q == 9'd0) &&
                  (hsub_q == 2'd0) && (vsub_q == 2'd0);
    disp_d      = in_win;
  end

  // Counter and output registers with synchronous reset.
  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      hcnt_q      <= 10'd0;
      vcnt_q      <= 10'd0;
      hsub_q      <= 2'd0;
      vsub_q      <= 2'd0;
      sx_q        <= 8'd0;
      sy_q        <= 9'd0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      de_q        <= 1'b0;
      sx_out_q    <= 8'd0;
      sy_out_q    <= 9'd0;
      pix_stb_q   <= 1'b0;
      frame_stb_q <= 1'b0;
      disp_q      <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      hsub_q      <= hsub_d;
      vsub_q      <= vsub_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      sx_out_q    <= sx_out_d;
      sy_out_q    <= sy_out_d;
      pix_stb_q   <= pix_stb_d;
      frame_stb_q <= frame_stb_d;
      disp_q      <= disp_d;
    end
  end

`ifdef GAME_BEAM_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Frame counter steps on the same edge that raises frame_stb.
  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
    end else if (frame_stb_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

  assign hsync           = hsync_q;
  assign vsync           = vsync_q;
  assign vga_de          = de_q;
  assign sx              = sx_out_q;
  assign sy              = sy_out_q;
  assign game_pix_stb    = pix_stb_q;
  assign frame_stb       = frame_stb_q;
  assign display_enabled = disp_q;

endmodule

// File: tb/tb_game_beam_gen.sv
// tb_game_beam_gen: drives two game_beam_gen instances on a shrunken raster
// (80x55 total) so whole frames fit in a short run: instance A with
// SCALE=1, instance B with SCALE=2 and the window at the top of the screen.
// Every cycle both instances are compared against a reference model that
// derives expected outputs from the cycle count since reset release.
module tb_game_beam_gen;

  localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4;
  localparam int VA = 48, VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;   // 80
  localparam int VT = VA + VFP + VSW + VBP;   // 55
  localparam int FT = HT * VT;                // 4400 cycles per frame
  localparam int GW = 16, GH = 20;
  localparam int A_S = 1, A_HO = 20, A_VO = 10;
  localparam int B_S = 2, B_HO = 8,  B_VO = 0;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [7:0]  sx;
    logic [8:0]  sy;
    logic        pix;
    logic        frm;
    logic        dis;
    logic [15:0] fc;
  } out_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_hs, a_vs, a_de, a_pix, a_frm, a_dis;
  logic [7:0]  a_sx;
  logic [8:0]  a_sy;
  logic [15:0] a_fc;
  logic        b_hs, b_vs, b_de, b_pix, b_frm, b_dis;
  logic [7:0]  b_sx;
  logic [8:0]  b_sy;
  logic [15:0] b_fc;

  game_beam_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .GAME_W(GW), .GAME_H(GH), .SCALE(A_S), .H_OFFSET(A_HO), .V_OFFSET(A_VO)
  ) u_a (
    .vga_pix_clk(clk), .rst(rst), .hsync(a_hs), .vsync(a_vs), .vga_de(a_de),
    .sx(a_sx), .sy(a_sy), .game_pix_stb(a_pix), .frame_stb(a_frm),
    .display_enabled(a_dis), .frame_cnt(a_fc)
  );

  game_beam_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .GAME_W(GW), .GAME_H(GH), .SCALE(B_S), .H_OFFSET(B_HO), .V_OFFSET(B_VO)
  ) u_b (
    .vga_pix_clk(clk), .rst(rst), .hsync(b_hs), .vsync(b_vs), .vga_de(b_de),
    .sx(b_sx), .sy(b_sy), .game_pix_stb(b_pix), .frame_stb(b_frm),
    .display_enabled(b_dis), .frame_cnt(b_fc)
  );

  // ---------------- reference model ----------------
  // t = cycles since reset release (t=0 shows reset values). Outputs in
  // cycle t describe raster position p = t-1.
  function automatic out_t model(int t, int ho, int vo, int s);
    out_t o;
    int p, h, v, first;
    logic in;
    o    = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (t == 0) return o;
    p  = t - 1;
    h  = p % HT;
    v  = (p / HT) % VT;
    o.hs = !(h >= HA + HFP && h < HA + HFP + HSW);
    o.vs = !(v >= VA + VFP && v < VA + VFP + VSW);
    o.de = (h < HA) && (v < VA);
    in = (h >= ho) && (h < ho + GW * s) && (v >= vo) && (v < vo + GH * s);
    o.dis = in;
    if (in) begin
      o.sx  = 8'((h - ho) / s);
      o.sy  = 9'((v - vo) / s);
      o.pix = ((h - ho) % s) == 0;
      o.frm = (h == ho) && (v == vo);
    end
`ifdef GAME_BEAM_FRAME_CNT_EN
    first = vo * HT + ho;
    if (p >= first) o.fc = 16'((p - first) / FT + 1);
`else
    first = 0;
`endif
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  int   n_cmp = 0;
  int   n_bad = 0;
  int   t = 0;
  logic use_model = 1'b1;
  out_t act_a, act_b;
  int   cnt_a_hs, cnt_a_vs, cnt_a_de, cnt_a_dis, cnt_a_frm;
  int   cnt_b_dis, cnt_b_pix, cnt_b_frm;

  task automatic chk_out(input string tag, input out_t obs, input out_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  task automatic clr_counts();
    cnt_a_hs = 0; cnt_a_vs = 0; cnt_a_de = 0; cnt_a_dis = 0; cnt_a_frm = 0;
    cnt_b_dis = 0; cnt_b_pix = 0; cnt_b_frm = 0;
  endtask

  // ---------------- driver ----------------
  // One clock: rst is only changed at negedges, so its value now is what
  // the coming posedge sees. Outputs are sampled at the following negedge.
  task automatic step();
    logic r;
    r = rst;
    @(negedge clk);
    if (r) t = 0;
    else t = t + 1;
    act_a = {a_hs, a_vs, a_de, a_sx, a_sy, a_pix, a_frm, a_dis, a_fc};
    act_b = {b_hs, b_vs, b_de, b_sx, b_sy, b_pix, b_frm, b_dis, b_fc};
    if (use_model) begin
      chk_out("beam_a", act_a, model(t, A_HO, A_VO, A_S));
      chk_out("beam_b", act_b, model(t, B_HO, B_VO, B_S));
    end
    cnt_a_hs  += int'(!a_hs);
    cnt_a_vs  += int'(!a_vs);
    cnt_a_de  += int'(a_de);
    cnt_a_dis += int'(a_dis);
    cnt_a_frm += int'(a_frm);
    cnt_b_dis += int'(b_dis);
    cnt_b_pix += int'(b_pix);
    cnt_b_frm += int'(b_frm);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    clr_counts();
    // Reset held: outputs at reset values every cycle.
    rst = 1'b1;
    run(4);
    rst = 1'b0;

    // One full frame from release.
    clr_counts();
    run(FT);
    chk_int("a_hsync_low", cnt_a_hs, VT * HSW);
    chk_int("a_vsync_low", cnt_a_vs, VSW * HT);
    chk_int("a_de_high", cnt_a_de, HA * VA);
    chk_int("a_disp_high", cnt_a_dis, GW * GH);
    chk_int("a_frame_stb", cnt_a_frm, 1);
    chk_int("b_disp_high", cnt_b_dis, GW * B_S * GH * B_S);
    chk_int("b_pix_stb", cnt_b_pix, GW * GH * B_S);
    chk_int("b_frame_stb", cnt_b_frm, 1);

    // Mid-frame reset at hcnt=30, vcnt=20 for one cycle.
    begin
      int guard;
      guard = 0;
      while (t % FT != 20 * HT + 30 && guard < FT) begin
        step();
        guard++;
      end
      chk_int("reach_reset_point", t % FT, 20 * HT + 30);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_int("rst_a_frame_stb", int'(a_frm), 0);
    chk_int("rst_a_pix_stb", int'(a_pix), 0);
    chk_int("rst_b_frame_stb", int'(b_frm), 0);
    clr_counts();
    run(A_VO * HT + A_HO);
    chk_int("a_no_early_stb", cnt_a_frm, 0);
    step();
    chk_int("a_first_stb_t", t, A_VO * HT + A_HO + 1);
    chk_int("a_first_stb", int'(a_frm), 1);

    // Randomised runs with resets of random length at random points.
    for (int k = 0; k < 6; k++) begin
      run($urandom_range(6000, 50));
      rst = 1'b1;
      run($urandom_range(3, 1));
      rst = 1'b0;
    end
    run(FT + 100);

`ifdef GAME_BEAM_FRAME_CNT_EN
    // Third strobe since release reads 3, then force a wrap.
    rst = 1'b1;
    step();
    rst = 1'b0;
    clr_counts();
    begin
      int guard;
      guard = 0;
      while (cnt_a_frm < 3 && guard < 4 * FT) begin
        step();
        guard++;
      end
      chk_int("fc_after_3", int'(a_fc), 3);
    end
    use_model = 1'b0;
    force u_a.frame_cnt_q = 16'hFFFF;
    step();
    release u_a.frame_cnt_q;
    step();
    chk_int("fc_forced", int'(a_fc), 16'hFFFF);
    clr_counts();
    begin
      int guard;
      guard = 0;
      while (cnt_a_frm < 1 && guard < 2 * FT) begin
        step();
        guard++;
      end
      chk_int("fc_wrap", int'(a_fc), 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_beam_gen.md
# game_beam_gen

Beam and strobe generator that drives the game drawing logic. It runs the physical 640x480@60 VGA raster from `vga_pix_clk`, emitting `hsync`/`vsync`/`vga_de` to the pins. It places a 224x288 game window inside that raster, scaled by an integer factor. Inside the window it produces the game-space beam signals `sx`, `sy`, `game_pix_stb`, `frame_stb` and `display_enabled` that the game consumes with its own one-stage input pipeline.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal porch/sync widths in pixels
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch/sync widths in lines
- `GAME_W` / `GAME_H`, 224 / 288, game window size in game pixels
- `SCALE`, 1, integer upscale (1..4); each game pixel is SCALE×SCALE physical pixels
- `H_OFFSET` / `V_OFFSET`, 208 / 96, physical position of the window's top-left pixel
- `vga_pix_clk`, in, 1, pixel clock, 25.175 MHz nominal
- `rst`, in, 1, synchronous, active-high reset
- `hsync`, out, 1, active-low horizontal sync
- `vsync`, out, 1, active-low vertical sync
- `vga_de`, out, 1, physical active area (h<H_ACTIVE && v<V_ACTIVE)
- `sx`, out, 8, game column 0..GAME_W-1
- `sy`, out, 9, game row 0..GAME_H-1
- `game_pix_stb`, out, 1, first physical pixel of each game pixel on every physical line in the window
- `frame_stb`, out, 1, one-cycle pulse at game pixel (0,0)
- `display_enabled`, out, 1, beam inside the game window
- `frame_cnt`, out, 16, frames since reset (see Configuration)

## Operation
- `hcnt` runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
- `vcnt` runs 0..V_TOTAL-1 (525). It increments when `hcnt` wraps and wraps to 0 after V_TOTAL-1.
- `hsync` is low for `hcnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). `vsync` is low for `vcnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- The window is `hcnt` in [H_OFFSET, H_OFFSET+GAME_W·SCALE) and `vcnt` in [V_OFFSET, V_OFFSET+GAME_H·SCALE).
- Horizontal sub-counter `hsub` runs 0..SCALE-1 inside the window.
  - It is cleared at the window's left edge.
  - `sx` increments when `hsub` wraps.
  - `sx` is 0 at the left edge and 0 outside the window.
- Vertical sub-counter `vsub` runs 0..SCALE-1 and advances at each window line end.
  - `sy` increments when `vsub` wraps.
  - `sy` is 0 on the first window line and 0 outside the window.
- `game_pix_stb` = in window && `hsub`==0. With SCALE=1 it is high on every window pixel.
- `frame_stb` = in window && `sx`==0 && `sy`==0 && `hsub`==0 && `vsub`==0. It fires exactly once per frame.
- `display_enabled` = in window. `vga_de` is independent of the window.
- Elaboration fails with `$error` if H_OFFSET+GAME_W·SCALE > H_ACTIVE, if V_OFFSET+GAME_H·SCALE > V_ACTIVE, or if SCALE is outside 1..4.
- All counter arithmetic is unsigned at declared widths. There is no overflow within the legal parameter range.

## Timing
- Every output is registered and reflects the counter state of the previous cycle (1-cycle latency).
- Reset values:
  - counters, `hsub`, `vsub`: 0
  - `hsync` and `vsync`: 1 (inactive)
  - `vga_de`, `sx`, `sy`, `game_pix_stb`, `frame_stb`, `display_enabled`, `frame_cnt`: 0
- Cycle numbering: cycle 0 is the first cycle with `rst`=0, and counters hold (0,0) in it.
- With defaults, `frame_stb` is first high in cycle 96·800+208+1 = 77009. It then repeats every 420000 cycles.
- Within one line, `sx` increments every SCALE cycles. `sy` changes only at line boundaries.
- `rst` asserted mid-frame takes effect at the next edge. No pulse (`frame_stb` or `game_pix_stb`) may appear in the cycle after the `rst` edge.
- Outputs are stable for the full cycle and carry no combinational path from `rst` to an output.

## Configuration
- Macro: `GAME_BEAM_FRAME_CNT_EN`.
- Defined: a 16-bit counter increments, wrapping at 65535→0, in the same cycle `frame_stb` is output high. `frame_cnt` exposes this counter and `rst` clears it to 0.
- Undefined: the counter is not synthesized and `frame_cnt` is tied to 0.
- All other behaviour is identical in both configurations.

## Test plan
- Reset, then run one full frame with defaults:
  - `hsync` low for 96 cycles per 800.
  - `vsync` low for 1600 cycles per 420000.
  - `vga_de` high for 640×480 = 307200 cycles.
- Window with defaults:
  - `frame_stb` first high in cycle 77009, exactly once per frame.
  - `display_enabled` high for 224×288 = 64512 cycles per frame.
  - `sx` runs 0..223 per line; `sy` runs 0..287.
- Build with SCALE=2, H_OFFSET=96, V_OFFSET=0 and GAME_H=240:
  - Each `sx` value is held for 2 cycles.
  - `game_pix_stb` is high on alternate window cycles.
  - Each `sy` value spans 2 lines.
- Assert `rst` for 1 cycle at `hcnt`=300, `vcnt`=200. The next cycle shows all outputs at their reset values. `frame_stb` then reappears 77009 cycles after release.
- With `GAME_BEAM_FRAME_CNT_EN`: `frame_cnt` reads 3 after the third `frame_stb`. Force the counter to 65535 and check it wraps to 0 on the next `frame_stb`. Without the macro, `frame_cnt` is constant 0.
